// File: rtl/xy_route_path_walker_pkg.sv
// Shared NoC definitions for the XY source-route walker:
// port codes, walker states, topology names and width helper.
package xy_route_path_walker_pkg;

    localparam logic [2:0] PORT_LOCAL = 3'd0;
    localparam logic [2:0] PORT_EAST  = 3'd1;
    localparam logic [2:0] PORT_NORTH = 3'd2;
    localparam logic [2:0] PORT_WEST  = 3'd3;
    localparam logic [2:0] PORT_SOUTH = 3'd4;

    localparam string TOPO_MESH  = "MESH";
    localparam string TOPO_TORUS = "TORUS";

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_WALK = 1'b1
    } walk_state_t;

    // Coordinate width for n routers, never below one bit.
    function automatic int log2c(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/xy_route_path_walker_dim_step.sv
// One routing dimension: picks the travel direction toward dst and
// the coordinate one hop along it (with wrap on a torus).
module xy_dim_step
    import xy_route_path_walker_pkg::*;
#(
    parameter int    N        = 4,
    parameter int    W        = 2,
    parameter string TOPOLOGY = TOPO_MESH
) (
    input  logic [W-1:0] i_cur,
    input  logic [W-1:0] i_dst,
    output logic         o_dir_pos,
    output logic         o_dir_neg,
    output logic [W-1:0] o_nxt
);

    localparam bit         IS_TORUS = (TOPOLOGY == TOPO_TORUS);
    localparam logic [W:0] NV       = (W+1)'(N);
    localparam logic [W-1:0] LAST   = W'(N - 1);

    logic [W:0]   w_cur;
    logic [W:0]   w_dst;
    logic [W:0]   w_fwd;
    logic [W:0]   w_bwd;
    logic         w_pos;
    logic         w_neg;
    logic [W-1:0] w_nxt;

    assign w_cur = {1'b0, i_cur};
    assign w_dst = {1'b0, i_dst};

    // Forward ring distance, exact for any N: one extra bit, no truncation.
    always_comb begin
        w_fwd = '0;
        w_bwd = '0;
        w_pos = 1'b0;
        w_neg = 1'b0;
        if (w_dst >= w_cur) begin
            w_fwd = w_dst - w_cur;
        end else begin
            w_fwd = w_dst + NV - w_cur;
        end
        w_bwd = NV - w_fwd;
        if (IS_TORUS) begin
            w_pos = (w_fwd != '0) && (w_fwd <= w_bwd);
            w_neg = (w_fwd != '0) && (w_fwd > w_bwd);
        end else begin
            w_pos = (w_dst > w_cur);
            w_neg = (w_dst < w_cur);
        end
    end

    always_comb begin
        w_nxt = i_cur;
        unique case (1'b1)
            w_pos: w_nxt = (i_cur == LAST) ? '0 : i_cur + W'(1);
            w_neg: w_nxt = (i_cur == '0) ? LAST : i_cur - W'(1);
            default: ;
        endcase
    end

    assign o_dir_pos = w_pos;
    assign o_dir_neg = w_neg;
    assign o_nxt     = w_nxt;

endmodule

// File: rtl/xy_route_path_walker.sv
// Dimension-ordered (X then Y) route walker: one request in,
// one beat per hop out, ending with the LOCAL ejection beat.
module xy_route_path_walker
    import xy_route_path_walker_pkg::*;
#(
    parameter int    NX       = 4,
    parameter int    NY       = 4,
    parameter string TOPOLOGY = TOPO_MESH,
    parameter int    Pw       = 3,
    parameter int    HCw      = 4,
    parameter int    RXw      = log2c(NX),
    parameter int    RYw      = log2c(NY)
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           req_valid,
    output logic           req_ready,
    input  logic [RXw-1:0] src_rx,
    input  logic [RYw-1:0] src_ry,
    input  logic [RXw-1:0] dst_rx,
    input  logic [RYw-1:0] dst_ry,
    output logic           hop_valid,
    input  logic           hop_ready,
    output logic [Pw-1:0]  hop_port,
    output logic [RXw-1:0] hop_rx,
    output logic [RYw-1:0] hop_ry,
    output logic           hop_last,
    output logic [HCw-1:0] hop_cnt
);

    localparam logic [RXw:0] NXV = (RXw+1)'(NX);
    localparam logic [RYw:0] NYV = (RYw+1)'(NY);

    walk_state_t    r_state;
    walk_state_t    w_state_nxt;
    logic [RXw-1:0] r_cx;
    logic [RXw-1:0] r_dx;
    logic [RYw-1:0] r_cy;
    logic [RYw-1:0] r_dy;
    logic [HCw-1:0] r_cnt;

    logic           w_xpos;
    logic           w_xneg;
    logic           w_ypos;
    logic           w_yneg;
    logic [RXw-1:0] w_xnxt;
    logic [RYw-1:0] w_ynxt;
    logic           w_xmove;
    logic           w_ymove;
    logic           w_at_dst;
    logic [Pw-1:0]  w_port;
    logic           w_accept;
    logic           w_step;

    xy_dim_step #(
        .N        (NX),
        .W        (RXw),
        .TOPOLOGY (TOPOLOGY)
    ) u_step_x (
        .i_cur     (r_cx),
        .i_dst     (r_dx),
        .o_dir_pos (w_xpos),
        .o_dir_neg (w_xneg),
        .o_nxt     (w_xnxt)
    );

    xy_dim_step #(
        .N        (NY),
        .W        (RYw),
        .TOPOLOGY (TOPOLOGY)
    ) u_step_y (
        .i_cur     (r_cy),
        .i_dst     (r_dy),
        .o_dir_pos (w_ypos),
        .o_dir_neg (w_yneg),
        .o_nxt     (w_ynxt)
    );

    assign w_xmove  = w_xpos | w_xneg;
    assign w_ymove  = w_ypos | w_yneg;
    assign w_at_dst = ~w_xmove & ~w_ymove;
    assign w_accept = req_valid & req_ready;
    assign w_step   = hop_valid & hop_ready & ~w_at_dst;

    // X is fully resolved before any Y hop is taken.
    always_comb begin
        w_port = Pw'(PORT_LOCAL);
        unique case (1'b1)
            w_xpos:             w_port = Pw'(PORT_EAST);
            w_xneg:             w_port = Pw'(PORT_WEST);
            (!w_xmove && w_ypos): w_port = Pw'(PORT_SOUTH);
            (!w_xmove && w_yneg): w_port = Pw'(PORT_NORTH);
            default: ;
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        req_ready   = 1'b0;
        hop_valid   = 1'b0;
        hop_port    = '0;
        hop_rx      = '0;
        hop_ry      = '0;
        hop_last    = 1'b0;
        hop_cnt     = '0;
        unique case (r_state)
            ST_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    w_state_nxt = ST_WALK;
                end
            end
            ST_WALK: begin
                hop_valid = 1'b1;
                hop_port  = w_port;
                hop_rx    = r_cx;
                hop_ry    = r_cy;
                hop_last  = w_at_dst;
                hop_cnt   = r_cnt;
                if (hop_ready && w_at_dst) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_cx    <= '0;
            r_cy    <= '0;
            r_dx    <= '0;
            r_dy    <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_cx  <= src_rx;
                r_cy  <= src_ry;
                r_dx  <= dst_rx;
                r_dy  <= dst_ry;
                r_cnt <= '0;
            end else if (w_step) begin
                if (w_xmove) begin
                    r_cx <= w_xnxt;
                end else begin
                    r_cy <= w_ynxt;
                end
                r_cnt <= r_cnt + HCw'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && w_accept) begin
            a_coord_range: assert (({1'b0, src_rx} < NXV) &&
                                   ({1'b0, dst_rx} < NXV) &&
                                   ({1'b0, src_ry} < NYV) &&
                                   ({1'b0, dst_ry} < NYV));
        end
    end

endmodule
